// File: rtl/rob_queue_if.sv
// rob_queue_if -- signal bundle between the reorder buffer and its clients.
//
// Groups the allocation (decode), writeback (functional units), operand
// lookup (issue) and commit (register file) signals of rob_queue.
//
// Handshakes: a transfer on a valid/ready pair happens in a cycle where both
// valid and ready are high at the rising clock edge. Valid never depends
// combinationally on ready. out_alloc_ready and out_commit_valid come only
// from registered state (plus reset and flush). in_alloc_valid and
// in_commit_ready may be driven freely by the client.
//
// Modports:
//   master -- client side: drives every in_* signal, observes every out_*.
//   slave  -- reorder buffer side: the reverse.
interface rob_queue_if #(
  parameter int ROB_DEPTH = 16,
  parameter int DATA_W    = 64,
  parameter int REG_IDX_W = 5
);
  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // allocation
  logic                 in_alloc_valid;
  logic [REG_IDX_W-1:0] in_alloc_dst;
  logic                 in_alloc_set_nzcv;
  logic                 out_alloc_ready;
  logic [IDX_W-1:0]     out_alloc_idx;

  // writeback
  logic                 in_wb_valid;
  logic [IDX_W-1:0]     in_wb_idx;
  logic [DATA_W-1:0]    in_wb_value;
  logic [3:0]           in_wb_nzcv;
  logic                 in_wb_mispred;

  // operand lookup
  logic [IDX_W-1:0]     in_src1_idx;
  logic [IDX_W-1:0]     in_src2_idx;
  logic                 out_src1_valid;
  logic                 out_src2_valid;
  logic [DATA_W-1:0]    out_src1_value;
  logic [DATA_W-1:0]    out_src2_value;

  // commit
  logic                 out_commit_valid;
  logic                 in_commit_ready;
  logic [IDX_W-1:0]     out_commit_idx;
  logic [REG_IDX_W-1:0] out_commit_dst;
  logic [DATA_W-1:0]    out_commit_value;
  logic                 out_commit_set_nzcv;
  logic [3:0]           out_commit_nzcv;

  // status
  logic                 out_flush;
  logic [CNT_W-1:0]     out_count;

  modport master (
    output in_alloc_valid, in_alloc_dst, in_alloc_set_nzcv,
    input  out_alloc_ready, out_alloc_idx,
    output in_wb_valid, in_wb_idx, in_wb_value, in_wb_nzcv, in_wb_mispred,
    output in_src1_idx, in_src2_idx,
    input  out_src1_valid, out_src2_valid, out_src1_value, out_src2_value,
    input  out_commit_valid,
    output in_commit_ready,
    input  out_commit_idx, out_commit_dst, out_commit_value,
    input  out_commit_set_nzcv, out_commit_nzcv,
    input  out_flush, out_count
  );

  modport slave (
    input  in_alloc_valid, in_alloc_dst, in_alloc_set_nzcv,
    output out_alloc_ready, out_alloc_idx,
    input  in_wb_valid, in_wb_idx, in_wb_value, in_wb_nzcv, in_wb_mispred,
    input  in_src1_idx, in_src2_idx,
    output out_src1_valid, out_src2_valid, out_src1_value, out_src2_value,
    output out_commit_valid,
    input  in_commit_ready,
    output out_commit_idx, out_commit_dst, out_commit_value,
    output out_commit_set_nzcv, out_commit_nzcv,
    output out_flush, out_count
  );
endinterface

// File: rtl/rob_queue.sv
// rob_queue -- circular reorder buffer with out-of-order writeback,
// in-order commit, operand lookup with writeback bypass and flush on a
// mispredicted branch reaching the head.
//
// Ports:
//   in_clk  -- sole clock, all state changes on its rising edge
//   in_rst  -- synchronous active-high reset, overrides everything
//   rob     -- rob_queue_if.slave bundle (alloc / wb / lookup / commit /
//              flush / count)
//
// ROB_DEPTH must be a power of two (>= 2) so pointers wrap by overflow.
module rob_queue #(
  parameter int ROB_DEPTH = 16,
  parameter int DATA_W    = 64,
  parameter int REG_IDX_W = 5
) (
  input  logic        in_clk,
  input  logic        in_rst,
  rob_queue_if.slave  rob
);
  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // control state
  logic [IDX_W-1:0]     head_q;
  logic [IDX_W-1:0]     tail_q;
  logic [CNT_W-1:0]     count_q;
  logic [ROB_DEPTH-1:0] busy_q;
  logic [ROB_DEPTH-1:0] done_q;
  logic [ROB_DEPTH-1:0] mispred_q;

  // per-entry payload (no reset: only meaningful while busy/done)
  logic [ROB_DEPTH-1:0] set_nzcv_q;
  logic [REG_IDX_W-1:0] dst_q   [ROB_DEPTH];
  logic [3:0]           nzcv_q  [ROB_DEPTH];
  logic [DATA_W-1:0]    value_q [ROB_DEPTH];

  logic alloc_ready;
  logic alloc_fire;
  logic commit_valid;
  logic commit_fire;
  logic flush;
  logic wb_fire;

  // Full is head==tail with count==ROB_DEPTH; only count tells full from empty.
  // Allocation is based on the registered count, so a slot freed by a commit
  // this cycle is not reusable until next cycle.
  assign alloc_ready  = (count_q < CNT_W'(ROB_DEPTH)) && !flush;
  assign alloc_fire   = rob.in_alloc_valid && alloc_ready;

  // Registered state only: a writeback this cycle to the head shows up as
  // committable next cycle. Reset masks it so no commit leaks during reset.
  assign commit_valid = !in_rst && (count_q != '0) && done_q[head_q];
  assign commit_fire  = commit_valid && rob.in_commit_ready;
  assign flush        = commit_fire && mispred_q[head_q];

  // Writebacks to idle entries are stale (squashed) results; drop them.
  assign wb_fire      = rob.in_wb_valid && busy_q[rob.in_wb_idx] && !flush;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      mispred_q <= '0;
    end else if (flush) begin
      // Everything younger than the mispredicted branch is squashed; the
      // queue restarts empty just past the retired branch.
      head_q    <= head_q + IDX_W'(1);
      tail_q    <= head_q + IDX_W'(1);
      count_q   <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      mispred_q <= '0;
    end else begin
      if (wb_fire) begin
        done_q[rob.in_wb_idx]    <= 1'b1;
        mispred_q[rob.in_wb_idx] <= rob.in_wb_mispred;
      end
      if (commit_fire) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= head_q + IDX_W'(1);
      end
      // The tail slot is never busy when allocation is allowed, so this
      // cannot collide with the writeback or commit above.
      if (alloc_fire) begin
        busy_q[tail_q]    <= 1'b1;
        done_q[tail_q]    <= 1'b0;
        mispred_q[tail_q] <= 1'b0;
        tail_q            <= tail_q + IDX_W'(1);
      end
      count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    end
  end

  always_ff @(posedge in_clk) begin
    if (alloc_fire) begin
      dst_q[tail_q]      <= rob.in_alloc_dst;
      set_nzcv_q[tail_q] <= rob.in_alloc_set_nzcv;
      nzcv_q[tail_q]     <= 4'h0;
    end
    if (wb_fire) begin
      value_q[rob.in_wb_idx] <= rob.in_wb_value;
      // Flags only matter for flag-setting instructions; others keep zero.
      if (set_nzcv_q[rob.in_wb_idx]) begin
        nzcv_q[rob.in_wb_idx] <= rob.in_wb_nzcv;
      end
    end
  end

  // Operand lookup: a result arriving this cycle for a live entry is
  // forwarded straight from the writeback bus.
  logic bypass1;
  logic bypass2;
  assign bypass1 = rob.in_wb_valid && (rob.in_wb_idx == rob.in_src1_idx)
                   && busy_q[rob.in_src1_idx];
  assign bypass2 = rob.in_wb_valid && (rob.in_wb_idx == rob.in_src2_idx)
                   && busy_q[rob.in_src2_idx];

  assign rob.out_src1_valid = bypass1 || done_q[rob.in_src1_idx];
  assign rob.out_src1_value = bypass1 ? rob.in_wb_value : value_q[rob.in_src1_idx];
  assign rob.out_src2_valid = bypass2 || done_q[rob.in_src2_idx];
  assign rob.out_src2_value = bypass2 ? rob.in_wb_value : value_q[rob.in_src2_idx];

  assign rob.out_alloc_ready     = alloc_ready;
  assign rob.out_alloc_idx       = tail_q;
  assign rob.out_commit_valid    = commit_valid;
  assign rob.out_commit_idx      = head_q;
  assign rob.out_commit_dst      = dst_q[head_q];
  assign rob.out_commit_value    = value_q[head_q];
  assign rob.out_commit_set_nzcv = set_nzcv_q[head_q];
  assign rob.out_commit_nzcv     = nzcv_q[head_q];
  assign rob.out_flush           = flush;
  assign rob.out_count           = count_q;
endmodule

// File: tb/tb_rob_queue.sv
// tb_rob_queue -- directed self-checking bench for rob_queue (16 x 64 bit).
// Inputs change 1 time unit after a rising edge; outputs are checked one
// more time unit later, well away from the next edge.
module tb_rob_queue;
  localparam int DEPTH = 16;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always #5 in_clk = ~in_clk;

  rob_queue_if #(.ROB_DEPTH(DEPTH), .DATA_W(64), .REG_IDX_W(5)) rif ();

  rob_queue #(.ROB_DEPTH(DEPTH), .DATA_W(64), .REG_IDX_W(5)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .rob    (rif)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle();
    rif.in_alloc_valid    = 1'b0;
    rif.in_alloc_dst      = '0;
    rif.in_alloc_set_nzcv = 1'b0;
    rif.in_wb_valid       = 1'b0;
    rif.in_wb_idx         = '0;
    rif.in_wb_value       = '0;
    rif.in_wb_nzcv        = '0;
    rif.in_wb_mispred     = 1'b0;
    rif.in_src1_idx       = '0;
    rif.in_src2_idx       = '0;
    rif.in_commit_ready   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    in_rst = 1'b1;
    tick();
    tick();
    in_rst = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      rif.in_alloc_valid = 1'b1;
      rif.in_alloc_dst   = 5'(i + 1);
      tick();
    end
    rif.in_alloc_valid = 1'b0;
  endtask

  task automatic wb(input int idx, input logic [63:0] val, input logic mp);
    rif.in_wb_valid   = 1'b1;
    rif.in_wb_idx     = 4'(idx);
    rif.in_wb_value   = val;
    rif.in_wb_mispred = mp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values
    do_reset();
    #1;
    check("rst_alloc_ready", 64'(rif.out_alloc_ready), 64'd1);
    check("rst_alloc_idx", 64'(rif.out_alloc_idx), 64'd0);
    check("rst_commit_valid", 64'(rif.out_commit_valid), 64'd0);
    check("rst_flush", 64'(rif.out_flush), 64'd0);
    check("rst_count", 64'(rif.out_count), 64'd0);
    check("rst_src1_valid", 64'(rif.out_src1_valid), 64'd0);

    // ---------------- fill
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      rif.in_alloc_valid = 1'b1;
      rif.in_alloc_dst   = 5'(i);
      #1;
      check("fill_idx", 64'(rif.out_alloc_idx), 64'(i));
      check("fill_ready", 64'(rif.out_alloc_ready), 64'd1);
      tick();
    end
    #1;
    check("full_count", 64'(rif.out_count), 64'd16);
    check("full_ready", 64'(rif.out_alloc_ready), 64'd0);
    check("full_idx_wrapped", 64'(rif.out_alloc_idx), 64'd0);
    tick();
    #1;
    check("full_refused_count", 64'(rif.out_count), 64'd16);

    // ---------------- out-of-order writeback
    do_reset();
    alloc_n(3);
    rif.in_commit_ready = 1'b1;
    wb(2, 64'd7, 1'b0);
    #1;
    check("ooo_no_commit_a", 64'(rif.out_commit_valid), 64'd0);
    tick();
    wb(0, 64'd5, 1'b0);
    #1;
    check("ooo_head_wb_same_cycle", 64'(rif.out_commit_valid), 64'd0);
    tick();
    rif.in_wb_valid = 1'b0;
    #1;
    check("ooo_commit_valid", 64'(rif.out_commit_valid), 64'd1);
    check("ooo_commit_idx", 64'(rif.out_commit_idx), 64'd0);
    check("ooo_commit_value", 64'(rif.out_commit_value), 64'd5);
    check("ooo_commit_dst", 64'(rif.out_commit_dst), 64'd1);
    tick();
    rif.in_src1_idx = 4'd2;
    #1;
    check("ooo_blocked", 64'(rif.out_commit_valid), 64'd0);
    check("ooo_count", 64'(rif.out_count), 64'd2);
    check("ooo_head_idx", 64'(rif.out_commit_idx), 64'd1);
    check("ooo_lookup_valid", 64'(rif.out_src1_valid), 64'd1);
    check("ooo_lookup_value", 64'(rif.out_src1_value), 64'd7);

    // ---------------- steady-state wrap: instr k allocated in cycle k,
    // written back in cycle k+1, committed in cycle k+2
    do_reset();
    for (int k = 0; k < 42; k++) begin
      int j;
      int c;
      rif.in_commit_ready   = 1'b1;
      rif.in_alloc_valid    = (k < 40);
      rif.in_alloc_dst      = 5'(k);
      rif.in_alloc_set_nzcv = k[0];
      j = k - 1;
      rif.in_wb_valid   = (k >= 1) && (k <= 40);
      rif.in_wb_idx     = 4'(j);
      rif.in_wb_value   = 64'(j * 3 + 1);
      rif.in_wb_nzcv    = 4'(j);
      rif.in_wb_mispred = 1'b0;
      #1;
      if (k < 40) check("wrap_alloc_idx", 64'(rif.out_alloc_idx), 64'(k % 16));
      if (k >= 2) begin
        c = k - 2;
        check("wrap_commit_valid", 64'(rif.out_commit_valid), 64'd1);
        check("wrap_commit_idx", 64'(rif.out_commit_idx), 64'(c % 16));
        check("wrap_commit_value", 64'(rif.out_commit_value), 64'(c * 3 + 1));
        check("wrap_commit_dst", 64'(rif.out_commit_dst), 64'(c % 32));
        check("wrap_commit_set_nzcv", 64'(rif.out_commit_set_nzcv), 64'(c % 2));
        check("wrap_commit_nzcv", 64'(rif.out_commit_nzcv),
              (c % 2 == 1) ? 64'(c % 16) : 64'd0);
      end
      if (k >= 2 && k < 40) check("wrap_count", 64'(rif.out_count), 64'd2);
      tick();
    end
    idle();
    #1;
    check("wrap_drained", 64'(rif.out_count), 64'd0);

    // ---------------- mispredict flush
    do_reset();
    alloc_n(5);
    wb(1, 64'd11, 1'b1);
    tick();
    wb(0, 64'd10, 1'b0);
    tick();
    rif.in_wb_valid     = 1'b0;
    rif.in_commit_ready = 1'b1;
    #1;
    check("mp_commit0_valid", 64'(rif.out_commit_valid), 64'd1);
    check("mp_commit0_idx", 64'(rif.out_commit_idx), 64'd0);
    check("mp_commit0_value", 64'(rif.out_commit_value), 64'd10);
    check("mp_commit0_flush", 64'(rif.out_flush), 64'd0);
    tick();
    rif.in_alloc_valid = 1'b1;
    wb(2, 64'h99, 1'b0);
    #1;
    check("mp_commit1_idx", 64'(rif.out_commit_idx), 64'd1);
    check("mp_commit1_value", 64'(rif.out_commit_value), 64'd11);
    check("mp_flush", 64'(rif.out_flush), 64'd1);
    check("mp_alloc_refused", 64'(rif.out_alloc_ready), 64'd0);
    tick();
    idle();
    rif.in_src1_idx = 4'd2;
    #1;
    check("mp_after_count", 64'(rif.out_count), 64'd0);
    check("mp_after_alloc_idx", 64'(rif.out_alloc_idx), 64'd2);
    check("mp_after_flush", 64'(rif.out_flush), 64'd0);
    check("mp_after_commit_valid", 64'(rif.out_commit_valid), 64'd0);
    check("mp_wb_discarded", 64'(rif.out_src1_valid), 64'd0);

    // ---------------- lookup bypass and ignored writeback
    do_reset();
    alloc_n(5);
    wb(0, 64'h11, 1'b0);
    tick();
    wb(4, 64'hAB, 1'b0);
    rif.in_src1_idx = 4'd4;
    rif.in_src2_idx = 4'd3;
    #1;
    check("byp_src1_valid", 64'(rif.out_src1_valid), 64'd1);
    check("byp_src1_value", 64'(rif.out_src1_value), 64'hAB);
    check("byp_src2_not_ready", 64'(rif.out_src2_valid), 64'd0);
    tick();
    wb(9, 64'h55, 1'b0);
    rif.in_src2_idx = 4'd9;
    #1;
    check("byp_src1_reg_valid", 64'(rif.out_src1_valid), 64'd1);
    check("byp_src1_reg_value", 64'(rif.out_src1_value), 64'hAB);
    check("idle_wb_no_bypass", 64'(rif.out_src2_valid), 64'd0);
    tick();
    rif.in_wb_valid = 1'b0;
    #1;
    check("idle_wb_ignored", 64'(rif.out_src2_valid), 64'd0);

    // ---------------- reset mid-run with 9 entries in flight
    alloc_n(4);
    #1;
    check("mid_count", 64'(rif.out_count), 64'd9);
    check("mid_head_ready", 64'(rif.out_commit_valid), 64'd1);
    in_rst = 1'b1;
    rif.in_alloc_valid  = 1'b1;
    rif.in_commit_ready = 1'b1;
    #1;
    check("mid_rst_no_commit", 64'(rif.out_commit_valid), 64'd0);
    check("mid_rst_no_flush", 64'(rif.out_flush), 64'd0);
    tick();
    in_rst = 1'b0;
    idle();
    #1;
    check("mid_after_count", 64'(rif.out_count), 64'd0);
    check("mid_after_commit_valid", 64'(rif.out_commit_valid), 64'd0);
    check("mid_after_alloc_idx", 64'(rif.out_alloc_idx), 64'd0);
    check("mid_after_alloc_ready", 64'(rif.out_alloc_ready), 64'd1);
    check("mid_after_src1_valid", 64'(rif.out_src1_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
